// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the burst-aware SDRAM arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_CMD   = 2'd1,
        RD_DATA  = 2'd2,
        WR_BURST = 2'd3
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_RD   = 2'b01;
    localparam logic [1:0] GNT_WR   = 2'b10;

endpackage

// File: rtl/burst_beat_counter.sv
// Remaining-beat counter shared by the read and write burst paths.
// A load coinciding with a decrement means the first beat is consumed on load.
module burst_beat_counter #(
    parameter int BW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [BW-1:0] i_load_val,
    input  logic          i_dec,
    output logic [BW-1:0] o_count,
    output logic          o_last
);

    localparam logic [BW-1:0] ONE = BW'(1);

    logic [BW-1:0] r_count;

    // beat count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_dec ? (i_load_val - ONE) : i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == ONE);

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Two-host burst arbiter (VGA reader, pixel-stream writer) in front of one SDRAM Avalon agent.
// Reads win ties until MAX_RD_STREAK consecutive read grants have starved a pending write.
module sdram_burst_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int BW            = 6,
    parameter int MAX_RD_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_read,
    input  logic [AW-1:0]   rd_address,
    input  logic [BW-1:0]   rd_burstcount,
    output logic            rd_waitrequest,
    output logic [DW-1:0]   rd_readdata,
    output logic            rd_readdatavalid,
    input  logic            wr_write,
    input  logic [AW-1:0]   wr_address,
    input  logic [BW-1:0]   wr_burstcount,
    input  logic [DW-1:0]   wr_writedata,
    input  logic [DW/8-1:0] wr_byteenable,
    output logic            wr_waitrequest,
    output logic            sd_read,
    output logic            sd_write,
    output logic [AW-1:0]   sd_address,
    output logic [BW-1:0]   sd_burstcount,
    output logic [DW-1:0]   sd_writedata,
    output logic [DW/8-1:0] sd_byteenable,
    input  logic            sd_waitrequest,
    input  logic [DW-1:0]   sd_readdata,
    input  logic            sd_readdatavalid,
    output logic [1:0]      grant,
    output logic            busy
);

    localparam logic [BW-1:0] ONE        = BW'(1);
    localparam int            SW         = $clog2(MAX_RD_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);

    arb_state_t    r_state;
    arb_state_t    w_next_state;
    logic [SW-1:0] r_rd_streak;

    logic [BW-1:0] w_rd_len;
    logic [BW-1:0] w_wr_len;
    logic          w_rd_accept;
    logic          w_rd_beat;
    logic          w_wr_beat;
    logic          w_wr_first;
    logic          w_wr_done;
    logic          w_rd_done;
    logic          w_gnt_rd;
    logic          w_gnt_wr;
    logic          w_cnt_load;
    logic [BW-1:0] w_cnt_load_val;
    logic          w_cnt_dec;
    logic [BW-1:0] w_cnt;
    logic          w_cnt_last;

    assign w_rd_len = (rd_burstcount == '0) ? ONE : rd_burstcount;
    assign w_wr_len = (wr_burstcount == '0) ? ONE : wr_burstcount;

    assign w_rd_accept = (r_state == RD_CMD) && rd_read && !sd_waitrequest;
    assign w_rd_beat   = (r_state == RD_DATA) && sd_readdatavalid;
    assign w_wr_beat   = (r_state == WR_BURST) && wr_write && !sd_waitrequest;
    // An empty counter inside WR_BURST marks the burst's first beat, which supplies the length.
    assign w_wr_first  = (w_cnt == '0);
    assign w_wr_done   = w_wr_beat && (w_wr_first ? (w_wr_len == ONE) : w_cnt_last);
    assign w_rd_done   = w_rd_beat && w_cnt_last;

    assign w_gnt_rd = (r_state == IDLE) && rd_read &&
                      !(wr_write && (r_rd_streak == STREAK_MAX));
    assign w_gnt_wr = (r_state == IDLE) && wr_write && !w_gnt_rd;

    assign w_cnt_load     = w_rd_accept || (w_wr_beat && w_wr_first);
    assign w_cnt_load_val = (r_state == WR_BURST) ? w_wr_len : w_rd_len;
    assign w_cnt_dec      = w_rd_beat || w_wr_beat;

    burst_beat_counter #(
        .BW (BW)
    ) u_beat_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_count    (w_cnt),
        .o_last     (w_cnt_last)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // read-streak tracking for write starvation bound
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_streak <= '0;
        end else if (w_gnt_wr) begin
            r_rd_streak <= '0;
        end else if (w_gnt_rd && wr_write && (r_rd_streak != STREAK_MAX)) begin
            r_rd_streak <= r_rd_streak + SW'(1);
        end else begin
            r_rd_streak <= r_rd_streak;
        end
    end

    // next-state selection
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_gnt_rd) begin
                    w_next_state = RD_CMD;
                end else if (w_gnt_wr) begin
                    w_next_state = WR_BURST;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RD_CMD: begin
                if (w_rd_accept) begin
                    w_next_state = RD_DATA;
                end else begin
                    w_next_state = RD_CMD;
                end
            end
            RD_DATA: begin
                if (w_rd_done) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RD_DATA;
                end
            end
            WR_BURST: begin
                if (w_wr_done) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WR_BURST;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Avalon forwarding and status decode
    always_comb begin
        sd_read        = 1'b0;
        sd_write       = 1'b0;
        sd_address     = rd_address;
        sd_burstcount  = rd_burstcount;
        sd_writedata   = wr_writedata;
        sd_byteenable  = wr_byteenable;
        rd_waitrequest = 1'b1;
        wr_waitrequest = 1'b1;
        grant          = GNT_NONE;
        busy           = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
            end
            RD_CMD: begin
                sd_read        = rd_read;
                rd_waitrequest = sd_waitrequest;
                grant          = GNT_RD;
            end
            RD_DATA: begin
                grant = GNT_RD;
            end
            WR_BURST: begin
                sd_write       = wr_write;
                sd_address     = wr_address;
                sd_burstcount  = wr_burstcount;
                wr_waitrequest = sd_waitrequest;
                grant          = GNT_WR;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign rd_readdata      = sd_readdata;
    assign rd_readdatavalid = sd_readdatavalid && rst_n;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed self-checking bench for sdram_burst_arbiter.
module tb_sdram_burst_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rd_read;
    logic [AW-1:0]   rd_address;
    logic [BW-1:0]   rd_burstcount;
    logic            rd_waitrequest;
    logic [DW-1:0]   rd_readdata;
    logic            rd_readdatavalid;
    logic            wr_write;
    logic [AW-1:0]   wr_address;
    logic [BW-1:0]   wr_burstcount;
    logic [DW-1:0]   wr_writedata;
    logic [DW/8-1:0] wr_byteenable;
    logic            wr_waitrequest;
    logic            sd_read;
    logic            sd_write;
    logic [AW-1:0]   sd_address;
    logic [BW-1:0]   sd_burstcount;
    logic [DW-1:0]   sd_writedata;
    logic [DW/8-1:0] sd_byteenable;
    logic            sd_waitrequest;
    logic [DW-1:0]   sd_readdata;
    logic            sd_readdatavalid;
    logic [1:0]      grant;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    sdram_burst_arbiter #(
        .AW (AW), .DW (DW), .BW (BW), .MAX_RD_STREAK (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rd_read          (rd_read),
        .rd_address       (rd_address),
        .rd_burstcount    (rd_burstcount),
        .rd_waitrequest   (rd_waitrequest),
        .rd_readdata      (rd_readdata),
        .rd_readdatavalid (rd_readdatavalid),
        .wr_write         (wr_write),
        .wr_address       (wr_address),
        .wr_burstcount    (wr_burstcount),
        .wr_writedata     (wr_writedata),
        .wr_byteenable    (wr_byteenable),
        .wr_waitrequest   (wr_waitrequest),
        .sd_read          (sd_read),
        .sd_write         (sd_write),
        .sd_address       (sd_address),
        .sd_burstcount    (sd_burstcount),
        .sd_writedata     (sd_writedata),
        .sd_byteenable    (sd_byteenable),
        .sd_waitrequest   (sd_waitrequest),
        .sd_readdata      (sd_readdata),
        .sd_readdatavalid (sd_readdatavalid),
        .grant            (grant),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] wdata [4];
        logic [1:0]    seq_exp [10];
        logic [1:0]    seq_got [10];
        logic [1:0]    prev_gnt;
        int            acc;
        int            pending;
        int            ngr;

        wdata = '{32'hDEAD_0001, 32'hBEEF_0002, 32'hCAFE_0003, 32'hF00D_0004};
        seq_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

        rst_n = 1'b0;
        rd_read = 1'b0; rd_address = '0; rd_burstcount = '0;
        wr_write = 1'b0; wr_address = '0; wr_burstcount = '0;
        wr_writedata = '0; wr_byteenable = '0;
        sd_waitrequest = 1'b0; sd_readdata = 32'h1234_5678; sd_readdatavalid = 1'b1;

        // reset state, with a beat arriving to confirm masking
        #2;
        check_eq("rst_grant", grant, 2'b00);
        check_eq("rst_sd_read", sd_read, 1'b0);
        check_eq("rst_sd_write", sd_write, 1'b0);
        check_eq("rst_rd_wait", rd_waitrequest, 1'b1);
        check_eq("rst_wr_wait", wr_waitrequest, 1'b1);
        check_eq("rst_rdv", rd_readdatavalid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        sd_readdatavalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick;

        // read-only burst of 8 at 0x100
        rd_read = 1'b1; rd_address = 32'h100; rd_burstcount = 6'd8;
        #1;
        check_eq("rd_pre_sd_read", sd_read, 1'b0);
        tick;
        check_eq("rd_cmd_sd_read", sd_read, 1'b1);
        check_eq("rd_cmd_grant", grant, 2'b01);
        check_eq("rd_cmd_addr", sd_address, 32'h100);
        check_eq("rd_cmd_bc", sd_burstcount, 6'd8);
        check_eq("rd_cmd_wait", rd_waitrequest, 1'b0);
        check_eq("rd_cmd_busy", busy, 1'b1);
        tick;
        rd_read = 1'b0;
        #1;
        check_eq("rd_data_sd_read", sd_read, 1'b0);
        check_eq("rd_data_grant", grant, 2'b01);
        check_eq("rd_data_wait", rd_waitrequest, 1'b1);
        for (int i = 0; i < 8; i++) begin
            sd_readdatavalid = 1'b1;
            sd_readdata = 32'hA0 + 32'(i);
            #1;
            check_eq("rd_beat_grant", grant, 2'b01);
            check_eq("rd_beat_rdv", rd_readdatavalid, 1'b1);
            check_eq("rd_beat_data", rd_readdata, 32'hA0 + 32'(i));
            tick;
        end
        sd_readdatavalid = 1'b0;
        #1;
        check_eq("rd_done_grant", grant, 2'b00);

        // burstcount 0 behaves as a single beat
        rd_read = 1'b1; rd_burstcount = 6'd0;
        tick;
        check_eq("bc0_grant", grant, 2'b01);
        tick;
        rd_read = 1'b0;
        sd_readdatavalid = 1'b1;
        #1;
        check_eq("bc0_data_grant", grant, 2'b01);
        tick;
        sd_readdatavalid = 1'b0;
        #1;
        check_eq("bc0_done_grant", grant, 2'b00);

        // stray beat in IDLE
        sd_readdatavalid = 1'b1; sd_readdata = 32'h5A5A;
        #1;
        check_eq("stray_rdv", rd_readdatavalid, 1'b1);
        check_eq("stray_data", rd_readdata, 32'h5A5A);
        tick;
        sd_readdatavalid = 1'b0;
        #1;
        check_eq("stray_grant", grant, 2'b00);
        check_eq("stray_busy", busy, 1'b0);

        // write-only burst of 4 with waitrequest toggling
        wr_write = 1'b1; wr_address = 32'h400; wr_burstcount = 6'd4;
        wr_writedata = wdata[0]; wr_byteenable = 4'hF;
        #1;
        check_eq("wr_pre_sd_write", sd_write, 1'b0);
        tick;
        acc = 0;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            sd_waitrequest = (c % 2 == 0);
            #1;
            check_eq("wr_sd_write", sd_write, 1'b1);
            check_eq("wr_grant", grant, 2'b10);
            check_eq("wr_data", sd_writedata, wdata[acc]);
            check_eq("wr_wait", wr_waitrequest, (c % 2 == 0));
            check_eq("wr_rd_wait", rd_waitrequest, 1'b1);
            if (c % 2 != 0) acc++;
            tick;
            if (acc < 4) wr_writedata = wdata[acc];
        end
        wr_write = 1'b0;
        sd_waitrequest = 1'b0;
        #1;
        check_eq("wr_accepted", acc, 4);
        check_eq("wr_done_grant", grant, 2'b00);
        check_eq("wr_done_busy", busy, 1'b0);

        // both hosts saturating with bursts of 2
        rd_read = 1'b1; rd_burstcount = 6'd2; rd_address = 32'h800;
        wr_write = 1'b1; wr_burstcount = 6'd2;
        pending = 0; ngr = 0; prev_gnt = 2'b00;
        for (int c = 0; c < 200 && ngr < 10; c++) begin
            sd_readdatavalid = (pending > 0);
            if (pending > 0) pending--;
            #1;
            if (grant != 2'b00 && prev_gnt == 2'b00) begin
                seq_got[ngr] = grant;
                ngr++;
            end
            prev_gnt = grant;
            if (sd_read && !sd_waitrequest) pending += int'(sd_burstcount);
            tick;
        end
        rd_read = 1'b0;
        sd_readdatavalid = 1'b0;
        for (int c = 0; c < 20 && busy; c++) tick;
        wr_write = 1'b0;
        #1;
        check_eq("starve_grants", ngr, 10);
        check_eq("starve_drain", busy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i < ngr) check_eq("starve_seq", seq_got[i], seq_exp[i]);
        end

        // reset during beat 3 of an 8-beat read
        rd_read = 1'b1; rd_address = 32'h200; rd_burstcount = 6'd8;
        tick;
        tick;
        rd_read = 1'b0;
        sd_readdatavalid = 1'b1;
        tick;
        tick;
        #1;
        check_eq("mid_grant", grant, 2'b01);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_sd_read", sd_read, 1'b0);
        check_eq("mid_rst_grant", grant, 2'b00);
        check_eq("mid_rst_rd_wait", rd_waitrequest, 1'b1);
        check_eq("mid_rst_wr_wait", wr_waitrequest, 1'b1);
        check_eq("mid_rst_rdv", rd_readdatavalid, 1'b0);
        sd_readdatavalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        rd_read = 1'b1; rd_address = 32'h300; rd_burstcount = 6'd1;
        tick;
        check_eq("post_rst_grant", grant, 2'b01);
        check_eq("post_rst_sd_read", sd_read, 1'b1);
        check_eq("post_rst_addr", sd_address, 32'h300);
        tick;
        rd_read = 1'b0;
        sd_readdatavalid = 1'b1;
        #1;
        check_eq("post_rst_data_grant", grant, 2'b01);
        tick;
        sd_readdatavalid = 1'b0;
        #1;
        check_eq("post_rst_done_grant", grant, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
